// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types and constants for the AXI-Lite master
package axi_lite_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;
  localparam int TO_CNT_W = 16;

  localparam logic RESP_OKAY = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WRITE,
    WRESP,
    DONE
  } state_t;

endpackage

// File: rtl/axi_lite_timeout.sv
// rtl/axi_lite_timeout.sv - watchdog counter for stalled slave handshakes
module axi_lite_timeout
  import axi_lite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [TO_CNT_W-1:0] LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th waiting cycle so the state leaves on that edge.
  assign expired = count_en && (cnt >= LIMIT);

endmodule

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI-Lite master; optional watchdog via AXI_LITE_MASTER_TIMEOUT_EN
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_t              state, state_d;
  logic                aw_done, w_done;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                timeout;
  logic                accept;
  logic                aw_hs, w_hs;

  assign accept = req_valid && req_ready;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;

  // Handshake outputs come from registered state only, never from the ready inputs.
  assign req_ready  = (state == IDLE) && !rst;
  assign arvalid    = (state == RADDR);
  assign rready     = (state == RDATA);
  assign awvalid    = (state == WRITE) && !aw_done;
  assign wvalid     = (state == WRITE) && !w_done;
  assign bready     = (state == WRESP);
  assign resp_valid = (state == DONE);
  assign araddr     = addr_q;
  assign awaddr     = addr_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  axi_lite_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_d != state),
    .count_en (state inside {RADDR, RDATA, WRITE, WRESP}),
    .expired  (timeout)
  );
`else
  wire unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept) state_d = req_wen ? WRITE : RADDR;
      RADDR: if (arready) state_d = RDATA;
      RDATA: if (rvalid) state_d = DONE;
      WRITE: if ((aw_done || awready) && (w_done || wready)) state_d = WRESP;
      WRESP: if (bvalid) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      // Flags live only for the duration of one WRITE phase.
      if (state_d != WRITE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (timeout) begin
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end else if (rready && rvalid) begin
        resp_rdata <= rdata;
        resp_err   <= (rresp != RESP_OKAY);
      end else if (bready && bvalid) begin
        resp_err   <= (bresp != RESP_OKAY);
      end
    end
  end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max cycles waiting on any slave handshake (used only under REQ-031).
REQ-002 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid in 1, req_ready out 1, req_wen in 1 (1=write), req_addr in 32, req_wdata in 32, req_wstrb in 4: core-side request.
REQ-005 SHALL have ports resp_valid out 1, resp_rdata out 32, resp_err out 1: core-side completion.
REQ-006 SHALL have AR ports araddr out 32, arvalid out 1, arready in 1.
REQ-007 SHALL have R ports rdata in 32, rresp in 1, rvalid in 1, rready out 1.
REQ-008 SHALL have AW ports awaddr out 32, awvalid out 1, awready in 1.
REQ-009 SHALL have W ports wdata out 32, wstrb out 4, wvalid out 1, wready in 1.
REQ-010 SHALL have B ports bresp in 1, bvalid in 1, bready out 1.

Function
REQ-011 SHALL implement states IDLE, RADDR, RDATA, WRITE, WRESP, DONE.
REQ-012 SHALL assert req_ready only in IDLE; request accepted when req_valid&&req_ready; addr/wdata/wstrb/wen latched that edge.
REQ-013 On accepted read SHALL go IDLE->RADDR; arvalid=1 in RADDR, araddr=latched addr, held stable until arvalid&&arready.
REQ-014 RADDR->RDATA on arvalid&&arready; rready=1 only in RDATA; RDATA->DONE on rvalid, latching rdata into resp_rdata and rresp into resp_err.
REQ-015 On accepted write SHALL go IDLE->WRITE asserting awvalid and wvalid together, same edge-following cycle.
REQ-016 In WRITE SHALL track aw_done/w_done flags independently; awvalid drops after its own handshake, wvalid after its own; either order or same cycle accepted.
REQ-017 WRITE->WRESP when both channels done (including both in same cycle); bready=1 only in WRESP.
REQ-018 WRESP->DONE on bvalid, latching bresp into resp_err; resp_rdata keeps prior value on writes.
REQ-019 DONE SHALL last exactly one cycle with resp_valid=1, then return to IDLE; core must accept (no backpressure).
REQ-020 Minimum latency: read = accept + 1 (AR) + 1 (R) + 1 (DONE) with zero-wait slave; write = accept + 1 (AW/W) + 1 (B) + 1 (DONE).
REQ-021 SHALL never have read and write transactions outstanding simultaneously; one transaction in flight.
REQ-022 valid outputs SHALL never depend combinationally on the corresponding ready inputs.
REQ-023 resp_err SHALL be 1 whenever captured rresp/bresp is nonzero.

Reset
REQ-024 rst SHALL force state IDLE, aw_done=w_done=0 on next posedge, regardless of current state (aborts in-flight transaction silently, no resp_valid).
REQ-025 Reset values: arvalid=awvalid=wvalid=rready=bready=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=0 during rst and 1 the cycle after.
REQ-026 araddr/awaddr/wdata/wstrb latches SHALL reset to 0.

Configuration
REQ-030 Macro AXI_LITE_MASTER_TIMEOUT_EN SHALL select the timeout watchdog.
REQ-031 With macro: an 8..16-bit counter clears on every state change and increments in RADDR, RDATA, WRITE, WRESP; reaching TIMEOUT_CYCLES SHALL drop all valid/ready outputs and enter DONE with resp_err=1, resp_rdata=0.
REQ-032 Without macro: no counter logic exists; master waits indefinitely.

Structure
REQ-033 Shared package axi_lite_pkg SHALL hold the state enum, RESP_OKAY=1'b0 constant, and address/data width constants (32).
REQ-034 Single module; optional sub-module axi_lite_timeout (counter + compare) instantiated only under AXI_LITE_MASTER_TIMEOUT_EN.

Verification
REQ-040 Read 0x8000_0004, slave arready=1, rvalid 10 cycles later with rdata=0xDEAD_BEEF -> one resp_valid pulse, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-041 Write 0x8000_0010, wdata=0x1234_5678, wstrb=4'b0011, awready delayed 3 cycles, wready=1 -> wvalid drops after 1 cycle, awvalid held 3 cycles stable, resp after bvalid, resp_err=0.
REQ-042 Write with wready delayed past awready, then bresp=1 -> both handshakes complete once, resp_err=1.
REQ-043 rst asserted in RDATA mid-transaction -> next cycle all valids/readies 0, no resp_valid, req_ready=1 after release.
REQ-044 Back-to-back read then write with req_valid held -> second accepted only in IDLE after DONE, no overlapping AR/AW.
REQ-045 With AXI_LITE_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready stuck 0 -> arvalid drops at cycle 16, resp_valid=1, resp_err=1.
